tag_ram_ctrl: RTL

Port controller and initiator for the 256x21 single-port tag RAM in the DCache.
- Takes read and write requests from the cache pipeline over a valid/ready handshake.
- Drives the RAM's CLKA-domain port (ENA/WEA/ADDRA/DINA) and returns read data with a held response.
- After reset and on every flush, sweeps all 256 entries to a known value, so the RAM's own reset is not needed.

---
 rtl/tag_ram_ctrl_if.sv | 35 +++
 rtl/tag_ram_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tag_ram_ctrl_if.sv
// Request/response and RAM-port bundle for tag_ram_ctrl.
// slave = controller side, master = pipeline plus RAM side.
interface tag_ram_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 21
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          flush_req;
  logic          init_busy;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_rst;
  logic [DW-1:0] ram_douta;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, flush_req, ram_douta,
    output req_ready, rsp_valid, rsp_rdata, init_busy,
           ram_ena, ram_wea, ram_addra, ram_dina, ram_rst
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, flush_req, ram_douta,
    input  req_ready, rsp_valid, rsp_rdata, init_busy,
           ram_ena, ram_wea, ram_addra, ram_dina, ram_rst
  );
endinterface

// File: rtl/tag_ram_ctrl.sv
// Port controller for the single-port DCache tag RAM: request handshake, held read response,
// and array initialisation. TAG_RAM_CTRL_INIT_EN selects the INIT sweep/flush; otherwise a RAM reset pulse.
module tag_ram_ctrl #(
  parameter int            AW       = 8,
  parameter int            DW       = 21,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic         CLKA,
  input  logic         RST,
  tag_ram_ctrl_if.slave bus
);

  logic          sweep;       // controller owns the RAM port this cycle
  logic          blk;         // requests refused this cycle
  logic [AW-1:0] sweep_addr;
  logic          acc, rd_acc, hs;
  logic          rsp_valid_q, rsp_valid_d;
  logic          first_q, first_d;
  logic [DW-1:0] hold_q, hold_d;

  assign hs = rsp_valid_q & bus.rsp_ready;

`ifdef TAG_RAM_CTRL_INIT_EN
  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk     = 1'b0;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.flush_req) begin
          blk = 1'b1;
          // A response delivered in the flush cycle itself needs no drain.
          if (!rsp_valid_q || bus.rsp_ready) begin
            state_d = S_INIT;
            cnt_d   = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        blk = 1'b1;
        if (!rsp_valid_q || bus.rsp_ready) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign sweep         = (state_q == S_INIT);
  assign sweep_addr    = cnt_q;
  assign bus.init_busy = sweep;
  assign bus.ram_rst   = 1'b0;

`else
  logic boot_q, ram_rst_q, flush_pend_q;
  logic flush_any, flush_now;

  // A flush waits for any outstanding response, then pulses the RAM reset.
  assign flush_any = bus.flush_req | flush_pend_q;
  assign flush_now = flush_any & (~rsp_valid_q | bus.rsp_ready);

  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      boot_q       <= 1'b0;
      ram_rst_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      boot_q       <= 1'b1;
      ram_rst_q    <= ~boot_q | flush_now;
      flush_pend_q <= flush_any & ~flush_now;
    end
  end

  assign blk           = ram_rst_q | flush_any | ~boot_q;
  assign sweep         = 1'b0;
  assign sweep_addr    = '0;
  assign bus.init_busy = 1'b0;
  assign bus.ram_rst   = ram_rst_q;
`endif

  assign bus.req_ready = ~sweep & ~blk & (~rsp_valid_q | bus.rsp_ready);
  assign acc           = bus.req_valid & bus.req_ready;
  assign rd_acc        = acc & ~bus.req_we;

  assign bus.ram_ena   = sweep | acc;
  assign bus.ram_wea   = sweep | (acc & bus.req_we);
  assign bus.ram_addra = sweep ? sweep_addr : bus.req_addr;
  assign bus.ram_dina  = sweep ? INIT_VAL   : bus.req_wdata;

  // RAM output is only valid in the first response cycle; hold it for stalls.
  always_comb begin
    rsp_valid_d = rd_acc | (rsp_valid_q & ~hs);
    first_d     = rd_acc;
    hold_d      = hold_q;
    if (first_q) hold_d = bus.ram_douta;
  end

  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      rsp_valid_q <= 1'b0;
      first_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = first_q ? bus.ram_douta : hold_q;

endmodule
